// File: rtl/gpio_seq_pkg.sv
// Shared definitions for the GPIO pattern sequencer.
// Holds the register offsets, the CTRL/STATUS bit positions, the entry field
// positions and the sequencer state type.
package gpio_seq_pkg;

    // Offsets within the sequencer register page
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_LEN    = 8'h08;
    localparam logic [7:0] OFF_PRESC  = 8'h0C;

    // Offset of the GPIO OUT register inside the GPIO page
    localparam logic [31:0] OFF_GPIO_OUT = 32'h0000_0004;

    // CTRL bits
    localparam int CTRL_EN     = 0;
    localparam int CTRL_LOOP   = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bits
    localparam int ST_BUSY    = 1'b0;
    localparam int ST_DONE    = 1;
    localparam int ST_STEP    = 2;
    localparam int ST_IDX_LSB = 8;

    // Pattern entry fields
    localparam int ENT_STEP_BIT = 15;
    localparam int ENT_DUR_LSB  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } seq_state_t;

    // Number of steps actually played for a programmed length
    function automatic logic [4:0] clamp_len(input logic [4:0] len, input logic [4:0] depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/gpio_seq_arb.sv
// GPIO bus arbiter: CPU accesses to the GPIO page pass straight through and
// always win; the sequencer's OUT write is driven only in CPU-free cycles.
// Also selects which read data the CPU sees.
module gpio_seq_arb
    import gpio_seq_pkg::*;
#(
    parameter logic [31:0] GPIO_BASE_ADDR = 32'h4000_1000
) (
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    input  logic        seq_hit,
    input  logic [31:0] seq_rdata,
    input  logic        seq_req,
    input  logic [31:0] seq_wdata,
    output logic        seq_grant,
    output logic [31:0] gpio_addr,
    output logic [31:0] gpio_wdata,
    output logic        gpio_we,
    output logic        gpio_re,
    input  logic [31:0] gpio_rdata
);

    logic cpu_gpio;

    assign cpu_gpio  = (cpu_we | cpu_re) && (cpu_addr[31:8] == GPIO_BASE_ADDR[31:8]);
    assign seq_grant = seq_req & ~cpu_gpio;
    assign cpu_rdata = (seq_hit & cpu_re) ? seq_rdata : gpio_rdata;

    // GPIO bus mux: CPU first, then a granted sequencer write, otherwise idle
    always_comb begin
        gpio_addr  = '0;
        gpio_wdata = '0;
        gpio_we    = 1'b0;
        gpio_re    = 1'b0;
        if (cpu_gpio) begin
            gpio_addr  = cpu_addr;
            gpio_wdata = cpu_wdata;
            gpio_we    = cpu_we;
            gpio_re    = cpu_re;
        end else if (seq_grant) begin
            gpio_addr  = GPIO_BASE_ADDR + OFF_GPIO_OUT;
            gpio_wdata = seq_wdata;
            gpio_we    = 1'b1;
        end
    end

endmodule

// File: rtl/gpio_seq.sv
// Timed GPIO pattern sequencer: plays a table of values onto GPIO OUT with a
// per-entry duration scaled by a prescaler, sharing the GPIO bus with the CPU.
// Optional feature macro: GPIO_SEQ_STEP_IRQ_EN (entry bit 15 raises STEP_FLAG).
module gpio_seq
    import gpio_seq_pkg::*;
#(
    parameter logic [31:0] SEQ_BASE_ADDR  = 32'h4000_2000,
    parameter logic [31:0] GPIO_BASE_ADDR = 32'h4000_1000,
    parameter int          DEPTH          = 8,
    parameter int          OUT_W          = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic [31:0] gpio_addr,
    output logic [31:0] gpio_wdata,
    output logic        gpio_we,
    output logic        gpio_re,
    input  logic [31:0] gpio_rdata,
    output logic        seq_active,
    output logic        seq_irq
);

    localparam int          IW         = $clog2(DEPTH);
    localparam logic [4:0]  DEPTH_L    = 5'(DEPTH);
    localparam logic [31:0] VALUE_MASK = (32'd1 << OUT_W) - 32'd1;
    localparam logic [31:0] ENTRY_MASK = 32'hFFFF_8000 | VALUE_MASK;

    seq_state_t  state_reg, state_next;
    logic        ctrl_en_reg, ctrl_loop_reg, ctrl_irq_en_reg, irq_en_next;
    logic        done_reg, done_next, finish;
    logic        step_flag, step_flag_next;
    logic [4:0]  len_reg, len_shadow_reg;
    logic [15:0] presc_reg, presc_shadow_reg;
    logic [3:0]  index_reg, index_next;
    logic [32:0] timer_reg, timer_next;
    logic        irq_reg;
    logic [31:0] entry_mem [DEPTH];

    // CPU decode of the sequencer page
    logic [7:0]    offset;
    logic          seq_hit, wr, wr_ctrl, wr_status, entry_hit, start, stop;
    logic [IW-1:0] entry_sel;
    logic [31:0]   seq_rdata, seq_wdata;
    logic          seq_req, seq_grant;

    assign offset    = cpu_addr[7:0];
    assign seq_hit   = (cpu_addr[31:8] == SEQ_BASE_ADDR[31:8]);
    assign wr        = cpu_we & seq_hit;
    assign wr_ctrl   = wr && (offset == OFF_CTRL);
    assign wr_status = wr && (offset == OFF_STATUS);
    assign entry_hit = (offset[7:6] == 2'b01) && (offset[1:0] == 2'b00)
                       && ({1'b0, offset[5:2]} < DEPTH_L);
    assign entry_sel = offset[2 +: IW];
    assign start     = wr_ctrl && cpu_wdata[CTRL_EN] && !ctrl_en_reg && (state_reg == IDLE);
    assign stop      = wr_ctrl && !cpu_wdata[CTRL_EN];

    // Current step: its write data and its period in clock cycles
    logic [IW-1:0] cur_idx;
    logic [15:0]   cur_dur;
    logic [16:0]   presc_plus;
    logic [32:0]   period;
    logic          last_step;

    assign cur_idx    = index_reg[IW-1:0];
    assign cur_dur    = entry_mem[cur_idx][ENT_DUR_LSB +: 16];
    assign presc_plus = {1'b0, presc_shadow_reg} + 17'd1;
    assign period     = 33'((cur_dur == 16'd0) ? 16'd1 : cur_dur) * 33'(presc_plus);
    assign last_step  = ({1'b0, index_reg} == (len_shadow_reg - 5'd1));
    assign seq_wdata  = entry_mem[cur_idx] & VALUE_MASK;
    assign seq_req    = (state_reg == LOAD) && !stop;

    gpio_seq_arb #(
        .GPIO_BASE_ADDR(GPIO_BASE_ADDR)
    ) u_arb (
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .seq_hit   (seq_hit),
        .seq_rdata (seq_rdata),
        .seq_req   (seq_req),
        .seq_wdata (seq_wdata),
        .seq_grant (seq_grant),
        .gpio_addr (gpio_addr),
        .gpio_wdata(gpio_wdata),
        .gpio_we   (gpio_we),
        .gpio_re   (gpio_re),
        .gpio_rdata(gpio_rdata)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // FSM next state, step index and timer; the timer holds the cycles left
    // until the next write so that the following LOAD lands exactly one
    // period after the granted write
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        timer_next = timer_reg;
        finish     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    if (clamp_len(len_reg, DEPTH_L) == 5'd0) begin
                        finish = 1'b1;
                    end else begin
                        state_next = LOAD;
                        index_next = '0;
                    end
                end
            end
            LOAD, WAIT: begin
                if ((state_reg == LOAD && seq_grant && period == 33'd1) ||
                    (state_reg == WAIT && timer_reg == 33'd1)) begin
                    if (!last_step) begin
                        index_next = index_reg + 4'd1;
                        state_next = LOAD;
                    end else if (ctrl_loop_reg) begin
                        index_next = '0;
                        state_next = LOAD;
                    end else begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end else if (state_reg == LOAD && seq_grant) begin
                    timer_next = period - 33'd1;
                    state_next = WAIT;
                end else if (state_reg == WAIT) begin
                    timer_next = timer_reg - 33'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (stop) begin
            state_next = IDLE;
            finish     = 1'b0;
        end
    end

    assign done_next   = finish | (done_reg & ~(wr_status & cpu_wdata[ST_DONE]));
    assign irq_en_next = wr_ctrl ? cpu_wdata[CTRL_IRQ_EN] : ctrl_irq_en_reg;

`ifdef GPIO_SEQ_STEP_IRQ_EN
    logic step_reg;
    assign step_flag_next = (seq_grant & entry_mem[cur_idx][ENT_STEP_BIT])
                            | (step_reg & ~(wr_status & cpu_wdata[ST_STEP]));
    assign step_flag      = step_reg;

    // Step flag: set by a granted write of a flagged entry, set beats W1C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_reg <= 1'b0;
        else        step_reg <= step_flag_next;
    end
`else
    assign step_flag_next = 1'b0;
    assign step_flag      = 1'b0;
`endif

    // Register file, start shadows, pattern table and interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en_reg      <= 1'b0;
            ctrl_loop_reg    <= 1'b0;
            ctrl_irq_en_reg  <= 1'b0;
            done_reg         <= 1'b0;
            len_reg          <= '0;
            len_shadow_reg   <= '0;
            presc_reg        <= '0;
            presc_shadow_reg <= '0;
            index_reg        <= '0;
            timer_reg        <= '0;
            irq_reg          <= 1'b0;
            for (int i = 0; i < DEPTH; i++) entry_mem[i] <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en_reg   <= cpu_wdata[CTRL_EN];
                ctrl_loop_reg <= cpu_wdata[CTRL_LOOP];
            end
            if (finish) ctrl_en_reg <= 1'b0;
            ctrl_irq_en_reg <= irq_en_next;
            done_reg        <= done_next;
            if (wr && offset == OFF_LEN)   len_reg   <= cpu_wdata[4:0];
            if (wr && offset == OFF_PRESC) presc_reg <= cpu_wdata[15:0];
            if (wr && entry_hit)           entry_mem[entry_sel] <= cpu_wdata & ENTRY_MASK;
            if (start) begin
                len_shadow_reg   <= clamp_len(len_reg, DEPTH_L);
                presc_shadow_reg <= presc_reg;
            end
            index_reg <= index_next;
            timer_reg <= timer_next;
            irq_reg   <= irq_en_next & (done_next | step_flag_next);
        end
    end

    // Combinational register read-back
    always_comb begin
        seq_rdata = '0;
        if (entry_hit) begin
            seq_rdata = entry_mem[entry_sel];
        end else begin
            case (offset)
                OFF_CTRL:   seq_rdata = {29'd0, ctrl_irq_en_reg, ctrl_loop_reg, ctrl_en_reg};
                OFF_STATUS: seq_rdata = {20'd0, index_reg, 5'd0, step_flag, done_reg,
                                         (state_reg != IDLE)};
                OFF_LEN:    seq_rdata = {27'd0, len_reg};
                OFF_PRESC:  seq_rdata = {16'd0, presc_reg};
                default:    seq_rdata = '0;
            endcase
        end
    end

    assign seq_active = (state_reg != IDLE);
    assign seq_irq    = irq_reg;

endmodule

// File: tb/tb_gpio_seq.sv
// Directed testbench for gpio_seq with a scoreboard of expected GPIO OUT
// writes (value and cycle) checked by a bus monitor.
module tb_gpio_seq;

    localparam logic [31:0] SEQ      = 32'h4000_2000;
    localparam logic [31:0] A_CTRL   = SEQ + 32'h00;
    localparam logic [31:0] A_STATUS = SEQ + 32'h04;
    localparam logic [31:0] A_LEN    = SEQ + 32'h08;
    localparam logic [31:0] A_PRESC  = SEQ + 32'h0C;
    localparam logic [31:0] A_ENTRY  = SEQ + 32'h40;
    localparam logic [31:0] GPIO_IN  = 32'h4000_1000;
    localparam logic [31:0] GPIO_OUT = 32'h4000_1004;
    localparam logic [31:0] IN_VAL   = 32'hCAFE_0123;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_we, cpu_re;
    logic [31:0] gpio_addr, gpio_wdata;
    logic        gpio_we, gpio_re;
    logic [31:0] gpio_rdata;
    logic        seq_active, seq_irq;

    typedef struct {
        logic [31:0] value;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t ex;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   k;
    logic [31:0] st5_exp;

    gpio_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .gpio_addr (gpio_addr),
        .gpio_wdata(gpio_wdata),
        .gpio_we   (gpio_we),
        .gpio_re   (gpio_re),
        .gpio_rdata(gpio_rdata),
        .seq_active(seq_active),
        .seq_irq   (seq_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign gpio_rdata = IN_VAL;

    // Bus monitor: every GPIO write is a sequencer write in this bench
    always @(negedge clk) begin
        if (rst_n && gpio_we) begin
            $display("gpio write cyc=%0d addr=%h data=%h", cyc, gpio_addr, gpio_wdata);
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_write observed=%h expected=none cyc=%0d", gpio_wdata, cyc);
            end
            if (exp_q.size() != 0) begin
                ex = exp_q.pop_front();
                compared++;
                assert (gpio_wdata === ex.value) else begin
                    mismatched++;
                    $error("FAIL write_value observed=%h expected=%h", gpio_wdata, ex.value);
                end
                compared++;
                assert (cyc === ex.cyc) else begin
                    mismatched++;
                    $error("FAIL write_cycle observed=%0d expected=%0d", cyc, ex.cyc);
                end
                compared++;
                assert (gpio_addr === GPIO_OUT) else begin
                    mismatched++;
                    $error("FAIL write_addr observed=%h expected=%h", gpio_addr, GPIO_OUT);
                end
            end
        end
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] v, input int c);
        exp_t e;
        e.value = v;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        @(posedge clk); #1;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
    endtask

    task automatic check_read(input logic [31:0] a, input logic [31:0] m,
                              input logic [31:0] e, input string tag);
        cpu_addr = a;
        cpu_re   = 1'b1;
        #2;
        check(cpu_rdata & m, e, tag);
        @(posedge clk); #1;
        cpu_re   = 1'b0;
        cpu_addr = '0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check({31'd0, seq_active}, 32'd0, "rst_active");
        check({31'd0, seq_irq}, 32'd0, "rst_irq");
        check({31'd0, gpio_we}, 32'd0, "rst_gpio_we");
        check_read(A_CTRL, 32'hFFFF_FFFF, 32'd0, "rst_ctrl");
        check_read(A_STATUS, 32'hFFFF_FFFF, 32'd0, "rst_status");

        // Three-step run, PRESC=0, durations 2/3/1
        cpu_write(A_PRESC, 32'd0);
        cpu_write(A_LEN, 32'd3);
        cpu_write(A_ENTRY + 0, 32'h0002_0001);
        cpu_write(A_ENTRY + 4, 32'h0003_0002);
        cpu_write(A_ENTRY + 8, 32'h0001_0004);
        cpu_write(A_ENTRY + 28, 32'hFFFF_FFFF);
        check_read(A_ENTRY + 0, 32'hFFFF_FFFF, 32'h0002_0001, "entry0_rb");
        check_read(A_ENTRY + 28, 32'hFFFF_FFFF, 32'hFFFF_807F, "entry7_mask");
        check_read(SEQ + 32'h60, 32'hFFFF_FFFF, 32'd0, "entry8_unmapped");
        check_read(SEQ + 32'h10, 32'hFFFF_FFFF, 32'd0, "off10_unmapped");
        k = cyc;
        push(32'h01, k + 1);
        push(32'h02, k + 3);
        push(32'h04, k + 6);
        cpu_write(A_CTRL, 32'h1);
        wait_until(k + 6);
        check_read(A_STATUS, 32'hFFFF_FFFF, 32'h0000_0201, "t1_status_last");
        check_read(A_STATUS, 32'h7, 32'h2, "t1_status_done");
        check_read(A_CTRL, 32'hFFFF_FFFF, 32'd0, "t1_en_cleared");

        // Prescaler 3, single entry with duration 0
        cpu_write(A_STATUS, 32'h2);
        check_read(A_STATUS, 32'h7, 32'h0, "w1c_done");
        cpu_write(A_PRESC, 32'd3);
        cpu_write(A_LEN, 32'd1);
        cpu_write(A_ENTRY + 0, 32'h0000_0055);
        k = cyc;
        push(32'h55, k + 1);
        cpu_write(A_CTRL, 32'h1);
        wait_until(k + 4);
        check_read(A_STATUS, 32'h7, 32'h1, "t2_busy");
        check_read(A_STATUS, 32'h7, 32'h2, "t2_done");

        // Looping run, stopped mid-WAIT
        cpu_write(A_STATUS, 32'h2);
        cpu_write(A_PRESC, 32'd0);
        cpu_write(A_LEN, 32'd2);
        cpu_write(A_ENTRY + 0, 32'h0002_0011);
        cpu_write(A_ENTRY + 4, 32'h0001_0022);
        k = cyc;
        push(32'h11, k + 1);
        push(32'h22, k + 3);
        push(32'h11, k + 4);
        push(32'h22, k + 6);
        push(32'h11, k + 7);
        cpu_write(A_CTRL, 32'h3);
        wait_until(k + 8);
        cpu_write(A_CTRL, 32'h0);
        check({31'd0, seq_active}, 32'd0, "t3_active_off");
        check_read(A_STATUS, 32'h1, 32'h0, "t3_busy_off");
        repeat (6) @(posedge clk);
        #1;
        check(exp_q.size(), 32'd0, "t3_queue_empty");

        // CPU GPIO read on the sequencer's due cycle
        cpu_write(A_ENTRY + 0, 32'h0002_000A);
        cpu_write(A_ENTRY + 4, 32'h0001_000B);
        k = cyc;
        push(32'h0A, k + 1);
        push(32'h0B, k + 4);
        cpu_write(A_CTRL, 32'h1);
        wait_until(k + 3);
        cpu_addr = GPIO_IN;
        cpu_re   = 1'b1;
        #2;
        check(cpu_rdata, IN_VAL, "t4_cpu_rdata");
        check(gpio_addr, GPIO_IN, "t4_gpio_addr");
        check({30'd0, gpio_re, gpio_we}, 32'h2, "t4_re_we");
        @(posedge clk); #1;
        cpu_re   = 1'b0;
        cpu_addr = '0;
        wait_until(k + 6);
        check_read(A_STATUS, 32'h7, 32'h2, "t4_done");
        cpu_write(A_STATUS, 32'h2);

        // LEN above DEPTH clamps to 8 steps; entry1 carries the step flag
        for (int i = 0; i < 8; i++) begin
            cpu_write(A_ENTRY + 32'(4 * i), 32'h0001_0000 | (i == 1 ? 32'h8000 : 32'h0) | 32'(16 + i));
        end
        cpu_write(A_LEN, 32'd20);
        check_read(A_LEN, 32'hFFFF_FFFF, 32'd20, "len_rb");
        check_read(A_ENTRY + 4, 32'hFFFF_FFFF, 32'h0001_8011, "entry1_rb");
        k = cyc;
        for (int i = 0; i < 8; i++) push(32'(16 + i), k + 1 + i);
        cpu_write(A_CTRL, 32'h1);
        wait_until(k + 9);
`ifdef GPIO_SEQ_STEP_IRQ_EN
        st5_exp = 32'h6;
`else
        st5_exp = 32'h2;
`endif
        check_read(A_STATUS, 32'h7, st5_exp, "t5_done_step");
        cpu_write(A_STATUS, 32'h6);
        check_read(A_STATUS, 32'h7, 32'h0, "t5_w1c");

        // Interrupt on DONE, cleared by W1C
        cpu_write(A_LEN, 32'd1);
        cpu_write(A_ENTRY + 0, 32'h0001_0033);
        check({31'd0, seq_irq}, 32'd0, "t6_irq_idle");
        k = cyc;
        push(32'h33, k + 1);
        cpu_write(A_CTRL, 32'h5);
        wait_until(k + 3);
        check({31'd0, seq_irq}, 32'd1, "t6_irq_set");
        check_read(A_CTRL, 32'hFFFF_FFFF, 32'h4, "t6_ctrl");
        cpu_write(A_STATUS, 32'h2);
        check({31'd0, seq_irq}, 32'd0, "t6_irq_clr");

        // LEN=0 start completes at once without a GPIO write
        cpu_write(A_LEN, 32'd0);
        cpu_write(A_CTRL, 32'h1);
        check_read(A_STATUS, 32'h7, 32'h2, "t7_done");
        check_read(A_CTRL, 32'h1, 32'h0, "t7_en_cleared");
        repeat (5) @(posedge clk);
        #1;
        check(exp_q.size(), 32'd0, "final_queue_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
